// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory port controller: access sizes,
// FSM states, lane mask generation and the default three-region memory map.
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } access_size_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } dmem_state_t;

    // Region 0 = ROM at 0x0000_0000, 1 = MMIO at 0x7000_0000, 2 = RAM at 0x8000_0000
    localparam logic [95:0] DEF_REGION_BASE = {32'h8000_0000, 32'h7000_0000, 32'h0000_0000};
    localparam logic [95:0] DEF_REGION_MASK = {3{32'hFFFF_0000}};

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_mask = 4'b0001;
            SIZE_HALF: size_mask = 4'b0011;
            SIZE_WORD: size_mask = 4'b1111;
            default:   size_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic is_unaligned(input logic [1:0] size, input logic [1:0] off);
        is_unaligned = ((size == SIZE_HALF) && (off == 2'd3)) ||
                       ((size == SIZE_WORD) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/dmem_lane_steer.sv
// Combinational lane steering: store data/byte-enable placement for both beats
// of an access, and load realignment, beat merge and sign/zero extension.
module dmem_lane_steer
    import mem_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_byteen0,
    output logic [3:0]  o_byteen1,
    output logic [31:0] o_wdata0,
    output logic [31:0] o_wdata1,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_off,
    input  logic        i_ld_zext,
    input  logic [31:0] i_ld_lo,
    input  logic [31:0] i_ld_hi,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_ld_shift;

    // Shifting across a 64-bit window puts the spill-over lanes in the upper word (beat 1)
    assign {o_byteen1, o_byteen0} = {4'b0000, size_mask(i_st_size)} << i_st_off;
    assign {o_wdata1, o_wdata0}   = {32'h0, i_st_wdata} << {i_st_off, 3'b000};

    assign w_ld_shift = 32'({i_ld_hi, i_ld_lo} >> {i_ld_off, 3'b000});

    always_comb begin
        o_ld_data = w_ld_shift;
        case (i_ld_size)
            SIZE_BYTE: o_ld_data = i_ld_zext ? {24'h0, w_ld_shift[7:0]}
                                             : {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
            SIZE_HALF: o_ld_data = i_ld_zext ? {16'h0, w_ld_shift[15:0]}
                                             : {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
            default:   o_ld_data = w_ld_shift;
        endcase
    end

endmodule

// File: rtl/dmem_port_ctrl.sv
// Data-memory port controller: decodes load/store requests onto N synchronous
// regions, splits unaligned accesses into two beats and reports faults.
module dmem_port_ctrl
    import mem_pkg::*;
#(
    parameter int                        NUM_REGIONS     = 3,
    parameter logic [NUM_REGIONS*32-1:0] REGION_BASE     = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*32-1:0] REGION_MASK     = DEF_REGION_MASK,
    parameter int                        ALLOW_UNALIGNED = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_addr,
    input  logic                      req_write,
    input  logic [2:0]                req_mode,
    input  logic [31:0]               req_wdata,
    output logic                      rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_fault,
    output logic [NUM_REGIONS-1:0]    region_en,
    output logic                      region_we,
    output logic [31:0]               region_addr,
    output logic [3:0]                region_byteen,
    output logic [31:0]               region_wdata,
    input  logic [NUM_REGIONS*32-1:0] region_rdata
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    dmem_state_t      r_state;
    logic [IDX_W-1:0] r_idx0;
    logic [IDX_W-1:0] r_idx1;
    logic [1:0]       r_off;
    logic [2:0]       r_mode;
    logic             r_write;
    logic [31:0]      r_wdata;
    logic [29:0]      r_word_addr;
    logic [31:0]      r_beat0_data;
    logic             r_rsp_valid;
    logic             r_rsp_fault;
    logic             r_rsp_split;

    logic [NUM_REGIONS-1:0] w_hit0;
    logic [NUM_REGIONS-1:0] w_hit1;
    logic [31:0]            w_rd [NUM_REGIONS];
    logic [IDX_W-1:0]       w_idx0;
    logic [IDX_W-1:0]       w_idx1;
    logic                   w_any0;
    logic                   w_any1;
    logic [31:0]            w_addr1;
    logic                   w_accept;
    logic                   w_unaligned;
    logic                   w_fault0;
    logic [1:0]             w_st_size;
    logic [1:0]             w_st_off;
    logic [31:0]            w_st_wdata;
    logic [3:0]             w_byteen0;
    logic [3:0]             w_byteen1;
    logic [31:0]            w_wdata0;
    logic [31:0]            w_wdata1;
    logic [31:0]            w_ld_lo;
    logic [31:0]            w_ld_hi;
    logic [31:0]            w_ld_data;

    // Beat 1 word address wraps naturally through the 30-bit word counter
    assign w_addr1 = {r_word_addr + 30'd1, 2'b00};

    generate
        for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
            assign w_hit0[gi] = (req_addr & REGION_MASK[gi*32 +: 32]) == REGION_BASE[gi*32 +: 32];
            assign w_hit1[gi] = (w_addr1  & REGION_MASK[gi*32 +: 32]) == REGION_BASE[gi*32 +: 32];
            assign w_rd[gi]   = region_rdata[gi*32 +: 32];
        end
    endgenerate

    // Scan high-to-low so the lowest-indexed hit wins
    always_comb begin
        w_idx0 = '0;
        w_idx1 = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_hit0[i]) w_idx0 = IDX_W'(i);
            if (w_hit1[i]) w_idx1 = IDX_W'(i);
        end
    end

    assign w_any0      = |w_hit0;
    assign w_any1      = |w_hit1;
    assign req_ready   = (r_state == IDLE);
    assign w_accept    = req_valid && req_ready;
    assign w_unaligned = is_unaligned(req_mode[1:0], req_addr[1:0]);
    assign w_fault0    = !w_any0 || (req_mode[1:0] == 2'd3) ||
                         (w_unaligned && (ALLOW_UNALIGNED == 0));

    assign w_st_size  = (r_state == SPLIT) ? r_mode[1:0] : req_mode[1:0];
    assign w_st_off   = (r_state == SPLIT) ? r_off       : req_addr[1:0];
    assign w_st_wdata = (r_state == SPLIT) ? r_wdata     : req_wdata;

    assign w_ld_lo = r_rsp_split ? r_beat0_data : w_rd[r_idx0];
    assign w_ld_hi = r_rsp_split ? w_rd[r_idx1] : 32'h0;

    dmem_lane_steer u_lane_steer (
        .i_st_size  (w_st_size),
        .i_st_off   (w_st_off),
        .i_st_wdata (w_st_wdata),
        .o_byteen0  (w_byteen0),
        .o_byteen1  (w_byteen1),
        .o_wdata0   (w_wdata0),
        .o_wdata1   (w_wdata1),
        .i_ld_size  (r_mode[1:0]),
        .i_ld_off   (r_off),
        .i_ld_zext  (r_mode[2]),
        .i_ld_lo    (w_ld_lo),
        .i_ld_hi    (w_ld_hi),
        .o_ld_data  (w_ld_data)
    );

    always_comb begin
        region_en     = '0;
        region_we     = 1'b0;
        region_addr   = 32'h0;
        region_byteen = 4'h0;
        region_wdata  = 32'h0;
        if (!reset) begin
            if ((r_state == IDLE) && w_accept && !w_fault0) begin
                region_en     = NUM_REGIONS'(1) << w_idx0;
                region_we     = req_write;
                region_addr   = {req_addr[31:2], 2'b00};
                region_byteen = w_byteen0;
                region_wdata  = w_wdata0;
            end else if ((r_state == SPLIT) && w_any1) begin
                region_en     = NUM_REGIONS'(1) << w_idx1;
                region_we     = r_write;
                region_addr   = w_addr1;
                region_byteen = w_byteen1;
                region_wdata  = w_wdata1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_idx0       <= '0;
            r_idx1       <= '0;
            r_off        <= 2'd0;
            r_mode       <= 3'd0;
            r_write      <= 1'b0;
            r_wdata      <= 32'h0;
            r_word_addr  <= 30'h0;
            r_beat0_data <= 32'h0;
            r_rsp_valid  <= 1'b0;
            r_rsp_fault  <= 1'b0;
            r_rsp_split  <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_idx0      <= w_idx0;
                        r_off       <= req_addr[1:0];
                        r_mode      <= req_mode;
                        r_write     <= req_write;
                        r_wdata     <= req_wdata;
                        r_word_addr <= req_addr[31:2];
                        r_rsp_split <= 1'b0;
                        if (w_fault0) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_fault <= 1'b1;
                        end else if (w_unaligned) begin
                            r_state <= SPLIT;
                        end else begin
                            r_rsp_valid <= 1'b1;
                        end
                    end
                end
                SPLIT: begin
                    // Beat 0 data is on its region's read port now; beat 1 arrives next cycle
                    r_beat0_data <= w_rd[r_idx0];
                    r_idx1       <= w_idx1;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_fault  <= !w_any1;
                    r_rsp_split  <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_fault = r_rsp_fault;
    assign rsp_rdata = (r_rsp_valid && !r_rsp_fault && !r_write) ? w_ld_data : 32'h0;

endmodule
